alu_op_issue: RTL and testbench

//   ID->EX issue stage for the ALU. Decodes ALUOp/Funct3/Funct7 into the 4-bit ALU

---
 rtl/alu_op_issue_if.sv | 33 +++
 rtl/alu_op_issue.sv | 96 +++++++++
 tb/tb_alu_op_issue.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/alu_op_issue_if.sv
// Handshake and data bundle between the ID stage, the ALU issue buffer and EX.
// The master drives the op and operands, and the slave (the issue stage) returns the buffered entry.
interface alu_op_issue_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 8
);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               ALUOp;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic [DATA_WIDTH-1:0]    RD1;
    logic [DATA_WIDTH-1:0]    RD2;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    SrcA;
    logic [DATA_WIDTH-1:0]    SrcB;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     Illegal;
    logic [CNT_WIDTH-1:0]     IllegalCount;

    modport master (
        output in_valid, ALUOp, Funct3, Funct7, RD1, RD2, flush, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Operation, Illegal, IllegalCount
    );

    modport slave (
        input  in_valid, ALUOp, Funct3, Funct7, RD1, RD2, flush, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Operation, Illegal, IllegalCount
    );
endinterface

// File: rtl/alu_op_issue.sv
// ID->EX issue stage: decodes ALUOp/Funct3/Funct7 into an ALU operation code and holds
// it with both operands in a one-entry valid/ready buffer. It supports flush and stall.
module alu_op_issue #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 8
) (
    input logic          clk,
    input logic          reset,
    alu_op_issue_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b0110);
    localparam logic [OPCODE_LENGTH-1:0] OP_LTU = OPCODE_LENGTH'(4'b0111);
    localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);
    localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;

    state_t                   state;
    state_t                   state_nxt;
    logic                     accept;
    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_ill;

    assign bus.in_ready  = reset & ~bus.flush & ((state == EMPTY) | bus.out_ready);
    assign bus.out_valid = (state == FULL);
    assign accept        = bus.in_valid & bus.in_ready;

    always_comb begin
        dec_op  = OP_ILL;
        dec_ill = 1'b1;
        case (bus.ALUOp)
            2'b00: begin
                dec_op  = OP_ADD;
                dec_ill = 1'b0;
            end
            2'b01: begin
                if (bus.Funct3 == 3'b000) begin
                    dec_op  = OP_EQ;
                    dec_ill = 1'b0;
                end else if (bus.Funct3 == 3'b110) begin
                    dec_op  = OP_LTU;
                    dec_ill = 1'b0;
                end
            end
            2'b10: begin
                // Every R/I-type op that is recognised has Funct7 == 0, so any other value is illegal.
                if (bus.Funct7 == 7'b0000000) begin
                    case (bus.Funct3)
                        3'b000: begin dec_op = OP_ADD; dec_ill = 1'b0; end
                        3'b111: begin dec_op = OP_AND; dec_ill = 1'b0; end
                        3'b011: begin dec_op = OP_LTU; dec_ill = 1'b0; end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush)
            state_nxt = EMPTY;
        else if (accept)
            state_nxt = FULL;
        else if (bus.out_ready)
            state_nxt = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.SrcA         <= '0;
            bus.SrcB         <= '0;
            bus.Operation    <= '0;
            bus.Illegal      <= 1'b0;
            bus.IllegalCount <= '0;
        end else if (accept) begin
            bus.SrcA      <= bus.RD1;
            bus.SrcB      <= bus.RD2;
            bus.Operation <= dec_op;
            bus.Illegal   <= dec_ill;
            if (dec_ill && bus.IllegalCount != CNT_MAX)
                bus.IllegalCount <= bus.IllegalCount + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_alu_op_issue.sv
// Bench for alu_op_issue: a decode vector table, directed handshake sequences and
// randomized traffic, all checked against a behavioural model of the issue buffer.
module tb_alu_op_issue;
    localparam int DW = 32;
    localparam int OL = 4;
    localparam int CW = 8;
    localparam int CNT_SAT = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_op_issue_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .CNT_WIDTH(CW)) bus ();

    alu_op_issue #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int passes = 0;
    int checks = 0;

    // Model state: the entry EX should currently see.
    bit          m_valid = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [3:0]  m_op = '0;
    bit          m_ill = 1'b0;
    int          m_cnt = 0;

    typedef struct {
        logic [1:0]  aop;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  exp_op;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [3:0] ref_decode(input logic [1:0] aop, input logic [2:0] f3,
                                               input logic [6:0] f7);
        if (aop == 2'd0) return 4'd2;
        if (aop == 2'd1 && f3 == 3'd0) return 4'd6;
        if (aop == 2'd1 && f3 == 3'd6) return 4'd7;
        if (aop == 2'd2 && f7 == 7'd0 && f3 == 3'd0) return 4'd2;
        if (aop == 2'd2 && f7 == 7'd0 && f3 == 3'd7) return 4'd0;
        if (aop == 2'd2 && f7 == 7'd0 && f3 == 3'd3) return 4'd7;
        return 4'hF;
    endfunction

    // One clock: drive inputs, check in_ready before the edge, update the model, check the registered outputs after it.
    task automatic step(input logic rst, input logic iv, input logic fl, input logic ordy,
                        input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b);
        bit exp_rdy;
        reset         = rst;
        bus.in_valid  = iv;
        bus.flush     = fl;
        bus.out_ready = ordy;
        bus.ALUOp     = aop;
        bus.Funct3    = f3;
        bus.Funct7    = f7;
        bus.RD1       = a;
        bus.RD2       = b;
        #1;
        exp_rdy = rst && !fl && (!m_valid || ordy);
        check("in_ready", bus.in_ready, exp_rdy);
        @(posedge clk);
        if (!rst) begin
            m_valid = 0; m_a = '0; m_b = '0; m_op = '0; m_ill = 0; m_cnt = 0;
        end else if (iv && exp_rdy) begin
            m_valid = 1; m_a = a; m_b = b;
            m_op  = ref_decode(aop, f3, f7);
            m_ill = (m_op == 4'hF);
            if (m_ill && m_cnt < CNT_SAT) m_cnt++;
        end else if (fl || ordy) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", bus.out_valid, m_valid);
        check("SrcA", bus.SrcA, m_a);
        check("SrcB", bus.SrcB, m_b);
        check("Operation", bus.Operation, m_op);
        check("Illegal", bus.Illegal, m_ill);
        check("IllegalCount", bus.IllegalCount, m_cnt);
    endtask

    initial begin
        logic [2:0] f3_pick;
        vecs[0]  = '{2'b10, 3'b000, 7'h00, 32'd5, 32'd7, 4'b0010, 1'b0};
        vecs[1]  = '{2'b00, 3'b101, 7'h55, 32'h11, 32'h22, 4'b0010, 1'b0};
        vecs[2]  = '{2'b01, 3'b000, 7'h13, 32'h33, 32'h44, 4'b0110, 1'b0};
        vecs[3]  = '{2'b01, 3'b110, 7'h00, 32'h55, 32'h66, 4'b0111, 1'b0};
        vecs[4]  = '{2'b01, 3'b001, 7'h00, 32'h77, 32'h88, 4'b1111, 1'b1};
        vecs[5]  = '{2'b10, 3'b111, 7'h00, 32'hDEADBEEF, 32'h0F0F0F0F, 4'b0000, 1'b0};
        vecs[6]  = '{2'b10, 3'b011, 7'h00, 32'hFFFFFFFF, 32'h1, 4'b0111, 1'b0};
        vecs[7]  = '{2'b10, 3'b000, 7'h20, 32'h9, 32'hA, 4'b1111, 1'b1};
        vecs[8]  = '{2'b10, 3'b111, 7'h01, 32'hB, 32'hC, 4'b1111, 1'b1};
        vecs[9]  = '{2'b10, 3'b001, 7'h00, 32'hD, 32'hE, 4'b1111, 1'b1};
        vecs[10] = '{2'b11, 3'b000, 7'h00, 32'h12345678, 32'h9ABCDEF0, 4'b1111, 1'b1};

        // Reset held two cycles with a pending op.
        step(0, 1, 0, 1, 2'b10, 3'b000, 7'h00, 32'd1, 32'd2);
        step(0, 1, 0, 1, 2'b10, 3'b000, 7'h00, 32'd1, 32'd2);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_count", bus.IllegalCount, 0);

        // Decode table, issued back to back with EX always ready.
        for (int i = 0; i < 11; i++) begin
            step(1, 1, 0, 1, vecs[i].aop, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            check("tbl_valid", bus.out_valid, 1'b1);
            check("tbl_op", bus.Operation, vecs[i].exp_op);
            check("tbl_ill", bus.Illegal, vecs[i].exp_ill);
            check("tbl_srca", bus.SrcA, vecs[i].a);
            check("tbl_srcb", bus.SrcB, vecs[i].b);
        end

        // BEQ stalled three cycles, then replaced by SLTU on the consume cycle.
        step(1, 1, 0, 1, 2'b01, 3'b000, 7'h00, 32'hAA, 32'hBB);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 2'b10, 3'b011, 7'h00, 32'hCC, 32'hDD);
            check("stall_op", bus.Operation, 4'b0110);
            check("stall_srca", bus.SrcA, 32'hAA);
        end
        step(1, 1, 0, 1, 2'b10, 3'b011, 7'h00, 32'hCC, 32'hDD);
        check("replace_op", bus.Operation, 4'b0111);
        check("replace_valid", bus.out_valid, 1'b1);

        // Flush beats both the stall and the incoming op.
        step(1, 1, 1, 0, 2'b00, 3'b000, 7'h00, 32'h1, 32'h2);
        check("flush_valid", bus.out_valid, 1'b0);
        check("flush_srca_kept", bus.SrcA, 32'hCC);
        step(1, 0, 0, 0, 2'b00, 3'b000, 7'h00, 32'h0, 32'h0);

        // Illegal counting from zero, then saturation.
        step(0, 0, 0, 0, 2'b00, 3'b000, 7'h00, 32'h0, 32'h0);
        step(1, 1, 0, 1, 2'b11, 3'b000, 7'h00, 32'h3, 32'h4);
        step(1, 1, 0, 1, 2'b10, 3'b000, 7'h20, 32'h5, 32'h6);
        check("ill_count2", bus.IllegalCount, 2);
        check("ill_op", bus.Operation, 4'b1111);
        for (int i = 0; i < CNT_SAT + 2; i++)
            step(1, 1, 0, 1, 2'b11, 3'($urandom), 7'($urandom), $urandom, $urandom);
        check("ill_saturated", bus.IllegalCount, CNT_SAT);

        // Reset during a stall drops the entry.
        step(1, 1, 0, 0, 2'b00, 3'b000, 7'h00, 32'h77, 32'h88);
        step(1, 0, 0, 0, 2'b00, 3'b000, 7'h00, 32'h0, 32'h0);
        step(0, 0, 0, 0, 2'b00, 3'b000, 7'h00, 32'h0, 32'h0);
        check("rst_stall_valid", bus.out_valid, 1'b0);
        check("rst_stall_count", bus.IllegalCount, 0);
        check("rst_stall_srca", bus.SrcA, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(4))
                0: f3_pick = 3'd0;
                1: f3_pick = 3'd3;
                2: f3_pick = 3'd6;
                3: f3_pick = 3'd7;
                default: f3_pick = 3'($urandom);
            endcase
            step(($urandom_range(49) != 0), ($urandom_range(3) != 0), ($urandom_range(9) == 0),
                 1'($urandom), 2'($urandom), f3_pick,
                 ($urandom_range(3) == 0) ? 7'($urandom) : 7'h00, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
